sync_down_timer: RTL and testbench
==================================

Name: sync_down_timer

Overview:
- Synchronous, loadable, programmable down counter/timer. It is the counting-down counterpart of the team's ripple up counter.
- Every bit is clocked from the single system clock. A borrow chain replaces the ripple carry.
- Adds a load handshake, start/stop control, one-shot or auto-reload mode, and a registered terminal-count pulse.
- Sits beside the up counter as the timing source for timeout and period generation.

Parameters:
- N, 3: MSB index; the count is N+1 bits wide (default 4 bits), matching the up counter's width convention.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- load_valid  input  1  a new count value is offered.
- load_value  input  N+1  count value to capture.
- load_ready  output  1  timer accepts a load this cycle.
- start  input  1  begin counting from the captured value.
- stop  input  1  pause counting; q is held.
- enable  input  1  count-enable qualifier; q decrements only when high.
- auto_reload  input  1  1 = reload on expiry and keep running; 0 = one-shot.
- q  output  N+1  current count.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot expired).
- tc  output  1  terminal-count pulse, one clock wide, registered.

Behaviour:
- Reset (reset low, async):
  - q=0, reload register=0, state=IDLE, tc=0.
  - busy=0, done=0, load_ready=1.
  - Asserting reset mid-count aborts immediately; no tc is produced.
- States: IDLE, ARMED, RUN, DONE.
- load_ready:
  - 1 in IDLE, ARMED and DONE; 0 in RUN.
  - A load occurs when load_valid && load_ready.
- Load:
  - q <= load_value and reload register <= load_value.
  - Next state is ARMED; done clears.
  - A load_value of 0 is legal.
- IDLE:
  - start is ignored.
  - A load moves to ARMED.
- ARMED:
  - start moves to RUN on the next edge; q is unchanged.
  - If load and start are both asserted, the load wins; the state stays ARMED with the new value.
- RUN, per cycle:
  - enable=0: hold q.
  - enable=1 and q!=0: q <= q-1, via the borrow chain; modulo arithmetic is never needed because q=0 is handled separately.
  - enable=1 and q==0 (expiry): tc=1 on the next cycle.
    - auto_reload=1: q <= reload register; stay in RUN.
    - auto_reload=0: q stays 0; go to DONE.
  - Period: load_value+1 enabled cycles per tc. Example: a load of 3 runs q=3,2,1,0, then tc.
  - stop=1 without expiry: go to ARMED, holding q; a later start resumes from the held value.
  - Expiry and stop in the same cycle:
    - Expiry is processed first and tc still fires.
    - auto_reload=1: q reloads and the state becomes ARMED.
    - auto_reload=0: the state becomes DONE.
  - auto_reload is sampled at the expiry cycle only.
- DONE:
  - done=1; q=0.
  - start is ignored; a load moves to ARMED.
- tc:
  - High for exactly one cycle after each expiry; never high two cycles in a row.
  - The exception is a reload value of 0 with enable continuously high, where tc stays high every cycle. This is intended (divide-by-1).
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so there is no combinational path from inputs.

Decomposition:
- Shared package contents:
  - State enum (IDLE, ARMED, RUN, DONE) with a 2-bit encoding.
  - Mode constants MODE_ONESHOT=0 and MODE_RELOAD=1.
- Sub-module down_cell: one bit of the counter with a synchronous load.
  - Inputs: clock, reset, load, d, borrow_in.
  - Outputs: q, borrow_out.
  - Toggles when borrow_in is high; borrow_out = borrow_in & ~q.
  - Instantiated N+1 times in a generate loop. Cell 0 has borrow_in = (state==RUN) & enable & (q!=0).

Test Plan:
- Reset: drive reset low mid-RUN with q=5 -> q=0, state IDLE, tc=0, load_ready=1, all immediately and without waiting for a clock.
- One-shot: load 3, start, enable high, auto_reload=0 -> q=3,2,1,0 on successive cycles; tc=1 for one cycle; done=1; q held at 0; a further start is ignored.
- Auto-reload: load 2, auto_reload=1, enable high -> q cycles 2,1,0,2,1,0; tc pulses every 3 cycles; busy stays 1.
- Enable gating and stop/resume: load 9, start, enable toggling 1010 -> q decrements only on enabled cycles. Then stop at q=6 -> ARMED with q=6 held; start -> resumes 5,4,...
- Handshake: in RUN, load_valid with value 7 -> load_ready=0 and q is unaffected. In ARMED, load and start together -> q=7, state ARMED.
- Edge cases:
  - Load 0 with auto_reload=1, enable high -> tc held high every cycle.
  - N=3, load 15 -> 16 enabled cycles to tc.
  - stop coinciding with expiry -> tc fires and the state becomes ARMED with q reloaded.

Source files
------------

// File: rtl/sync_down_timer_pkg.sv
// Shared types and constants for the synchronous down timer.
// This package holds the controller state encoding and the auto_reload mode values.
package sync_down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/sync_down_timer_if.sv
// Load handshake, run control and status bundle of the down timer.
// The master drives control and load inputs; the slave is the timer itself.
interface sync_down_timer_if #(parameter int N = 3);

  logic         load_valid;
  logic [N:0]   load_value;
  logic         load_ready;
  logic         start;
  logic         stop;
  logic         enable;
  logic         auto_reload;
  logic [N:0]   q;
  logic         busy;
  logic         done;
  logic         tc;

  modport master (
    output load_valid, load_value, start, stop, enable, auto_reload,
    input  load_ready, q, busy, done, tc
  );

  modport slave (
    input  load_valid, load_value, start, stop, enable, auto_reload,
    output load_ready, q, busy, done, tc
  );

endinterface

// File: rtl/sync_down_timer_down_cell.sv
// One bit of the synchronous down counter: a synchronous load has priority over toggling.
// A borrow propagates upward only through bits that are currently 0.
module down_cell (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic d,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  // NOTE: sequential state is updated with non-blocking assignments so every cell
  // samples its neighbours' pre-edge values, regardless of evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         q <= 1'b0;
    else if (load)      q <= d;
    else if (borrow_in) q <= ~q;
  end

  assign borrow_out = borrow_in & ~q;

endmodule

// File: rtl/sync_down_timer.sv
// Loadable down timer with start/stop, one-shot or auto-reload, and a registered tc pulse.
// Counter bits are down_cell instances linked by a borrow chain; the FSM gates the chain.
module sync_down_timer #(
  parameter int N = 3
) (
  input  logic             clock,
  input  logic             reset,
  sync_down_timer_if.slave bus
);

  import sync_down_timer_pkg::*;

  state_t     state, state_nxt;
  logic [N:0] q;
  logic [N:0] reload_reg;
  logic [N:0] cell_d;
  logic [N+1:0] borrow;
  logic       ready;
  logic       load_fire;
  logic       run;
  logic       expiry;
  logic       cell_load;
  logic       tc_reg;
  logic       unused_borrow_msb;

  assign run       = (state == ST_RUN);
  assign ready     = !run;
  assign load_fire = bus.load_valid && ready;

  // q==0 is handled as expiry, so the chain never has to wrap through zero.
  assign borrow[0] = run & bus.enable & (q != '0);
  assign expiry    = run & bus.enable & (q == '0);

  assign cell_load = load_fire | (expiry & (bus.auto_reload == MODE_RELOAD));
  assign cell_d    = load_fire ? bus.load_value : reload_reg;

  for (genvar i = 0; i <= N; i++) begin : g_cell
    down_cell u_cell (
      .clock      (clock),
      .reset      (reset),
      .load       (cell_load),
      .d          (cell_d[i]),
      .borrow_in  (borrow[i]),
      .q          (q[i]),
      .borrow_out (borrow[i+1])
    );
  end

  assign unused_borrow_msb = borrow[N+1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else begin
      state  <= state_nxt;
      tc_reg <= expiry;
      if (load_fire) reload_reg <= bus.load_value;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (load_fire) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (load_fire)      state_nxt = ST_ARMED;
        else if (bus.start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (expiry) begin
          if (bus.auto_reload == MODE_RELOAD) state_nxt = bus.stop ? ST_ARMED : ST_RUN;
          else                                state_nxt = ST_DONE;
        end else if (bus.stop) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_DONE: begin
        if (load_fire) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.q          = q;
  assign bus.load_ready = ready;
  assign bus.busy       = run;
  assign bus.done       = (state == ST_DONE);
  assign bus.tc         = tc_reg;

endmodule

// File: tb/tb_sync_down_timer.sv
// Self-checking bench for sync_down_timer: vector table, corner sequences and a
// randomized run against a behavioural model of the timer.
module tb_sync_down_timer;

  localparam int N = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  sync_down_timer_if #(.N(N)) bus ();

  sync_down_timer #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       lv;
    logic [3:0] val;
    logic       st;
    logic       sp;
    logic       en;
    logic       ar;
    logic [3:0] eq;
    logic       ebusy;
    logic       edone;
    logic       etc;
  } vec_t;

  typedef enum {M_IDLE, M_ARMED, M_RUN, M_DONE} mmode_t;

  mmode_t m_mode;
  int     m_q, m_reload;
  bit     m_tc;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lv, input logic [3:0] val, input logic st,
                       input logic sp, input logic en, input logic ar);
    bus.load_valid  = lv;
    bus.load_value  = val;
    bus.start       = st;
    bus.stop        = sp;
    bus.enable      = en;
    bus.auto_reload = ar;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
    m_mode = M_IDLE; m_q = 0; m_reload = 0; m_tc = 0;
  endtask

  // Model: one clock edge computed directly from the timer's rules.
  task automatic model_step(input logic lv, input int val, input logic st,
                            input logic sp, input logic en, input logic ar);
    m_tc = 0;
    if (lv && m_mode != M_RUN) begin
      m_q = val; m_reload = val; m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (st) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (en && m_q == 0) begin
        m_tc = 1;
        if (ar) begin
          m_q = m_reload;
          m_mode = sp ? M_ARMED : M_RUN;
        end else begin
          m_mode = M_DONE;
        end
      end else begin
        if (en) m_q = m_q - 1;
        if (sp) m_mode = M_ARMED;
      end
    end
  endtask

  vec_t tbl[15];

  initial begin
    int cyc;
    bit lv, st, sp, en, ar;
    logic [3:0] val;
    int exp_pack, act_pack;

    //        lv val st sp en ar   q  busy done tc
    tbl[0]  = '{1, 3, 0, 0, 0, 0,  3, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0,  3, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 0,  2, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 0,  1, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 1, 0,  0, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 0,  0, 0, 1, 1};
    tbl[6]  = '{0, 0, 1, 0, 1, 0,  0, 0, 1, 0};
    tbl[7]  = '{1, 2, 0, 0, 0, 1,  2, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 0, 1,  2, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 1,  1, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 1,  0, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 1,  2, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 1, 1,  1, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 1,  0, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 1, 1,  2, 1, 0, 1};

    drive(0, 0, 0, 0, 0, 0);
    #3;
    check("reset_q", bus.q, 0);
    check("reset_ready", bus.load_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_tc", bus.tc, 0);
    do_reset();

    // IDLE ignores start.
    drive(0, 0, 1, 0, 1, 0);
    tick();
    check("idle_start_ignored", bus.busy, 0);

    // One-shot then auto-reload, table driven.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].lv, tbl[i].val, tbl[i].st, tbl[i].sp, tbl[i].en, tbl[i].ar);
      tick();
      check($sformatf("vec%0d_q", i), bus.q, tbl[i].eq);
      check($sformatf("vec%0d_busy", i), bus.busy, tbl[i].ebusy);
      check($sformatf("vec%0d_done", i), bus.done, tbl[i].edone);
      check($sformatf("vec%0d_tc", i), bus.tc, tbl[i].etc);
      check($sformatf("vec%0d_ready", i), bus.load_ready, !tbl[i].ebusy);
    end

    // Enable gating, stop/resume, handshake.
    do_reset();
    drive(1, 9, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0); tick(); check("gate_1", bus.q, 8);
    drive(0, 0, 0, 0, 0, 0); tick(); check("gate_0", bus.q, 8);
    drive(0, 0, 0, 0, 1, 0); tick(); check("gate_1b", bus.q, 7);
    drive(0, 0, 0, 0, 0, 0); tick(); check("gate_0b", bus.q, 7);
    drive(0, 0, 0, 0, 1, 0); tick(); check("gate_1c", bus.q, 6);
    drive(0, 0, 0, 1, 0, 0); tick();
    check("stop_q", bus.q, 6);
    check("stop_busy", bus.busy, 0);
    drive(0, 0, 0, 0, 1, 0); tick(); check("armed_hold", bus.q, 6);
    drive(0, 0, 1, 0, 0, 0); tick(); check("resume_busy", bus.busy, 1);
    drive(0, 0, 0, 0, 1, 0); tick(); check("resume_5", bus.q, 5);
    tick(); check("resume_4", bus.q, 4);
    drive(1, 7, 0, 0, 0, 0);
    #1;
    check("run_ready", bus.load_ready, 0);
    tick();
    check("run_load_ignored", bus.q, 4);
    check("run_load_busy", bus.busy, 1);
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(1, 7, 1, 0, 0, 0); tick();
    check("load_wins_q", bus.q, 7);
    check("load_wins_busy", bus.busy, 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("load_wins_armed", bus.busy, 0);

    // Load 0 with auto-reload: tc every cycle.
    drive(1, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("div1_tc%0d", i), bus.tc, 1);
      check($sformatf("div1_busy%0d", i), bus.busy, 1);
    end

    // Load 15: sixteen enabled cycles to tc.
    do_reset();
    drive(1, 15, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.tc) begin
        cyc = i;
        break;
      end
    end
    check("period15", cyc, 16);

    // Stop coincident with expiry in auto-reload.
    do_reset();
    drive(1, 1, 0, 0, 0, 1); tick();
    drive(0, 0, 1, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1, 1); tick(); check("sx_q0", bus.q, 0);
    drive(0, 0, 0, 1, 1, 1); tick();
    check("sx_tc", bus.tc, 1);
    check("sx_q", bus.q, 1);
    check("sx_busy", bus.busy, 0);
    check("sx_ready", bus.load_ready, 1);
    drive(0, 0, 0, 0, 1, 1); tick();
    check("sx_tc_once", bus.tc, 0);
    check("sx_hold", bus.q, 1);

    // Asynchronous reset mid-run with q=5.
    do_reset();
    drive(1, 5, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    check("pre_reset_q", bus.q, 5);
    #2 reset = 1'b0;
    #1;
    check("areset_q", bus.q, 0);
    check("areset_busy", bus.busy, 0);
    check("areset_tc", bus.tc, 0);
    check("areset_ready", bus.load_ready, 1);
    #2 reset = 1'b1;
    drive(0, 0, 1, 0, 1, 0); tick();
    check("areset_idle", bus.busy, 0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lv  = ($urandom_range(0, 7) == 0);
      val = 4'($urandom_range(0, 15));
      st  = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ar  = $urandom_range(0, 1) != 0;
      // Stop is only combined with enable where no decrement would occur.
      if (m_mode == M_RUN && m_q != 0 && en) sp = 0;
      drive(lv, val, st, sp, en, ar);
      model_step(lv, int'(val), st, sp, en, ar);
      tick();
      exp_pack = {m_q[3:0], (m_mode == M_RUN), (m_mode == M_DONE), m_tc, (m_mode != M_RUN)};
      act_pack = {bus.q, bus.busy, bus.done, bus.tc, bus.load_ready};
      check($sformatf("rand%0d", i), act_pack, exp_pack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
